bus_arbiter: RTL and testbench

Two-requester arbiter placed in front of the Manta core bus chain. It lets the host bridge (requester 0) and an on-chip requester such as a scanner or debug sequencer (requester 1) share one 16-bit addr/data/rw/valid bus. It keeps at most one transaction outstanding and routes each response back to the requester that issued it. It recovers from cores that never answer via a timeout.

---
 rtl/bus_arbiter.sv | 137 +++++++++++++
 tb/tb_bus_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-requester round-robin front end for the Manta core bus chain.
// One transaction outstanding at a time; responses are routed back to the
// issuing requester, and a missing response is turned into an error strobe.
module bus_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_data,
  input  logic                  req0_rw,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  output logic [DATA_WIDTH-1:0] resp0_data,
  output logic                  resp0_rw,
  output logic                  resp0_err,
  output logic                  resp0_valid,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_data,
  input  logic                  req1_rw,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  output logic [DATA_WIDTH-1:0] resp1_data,
  output logic                  resp1_rw,
  output logic                  resp1_err,
  output logic                  resp1_valid,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_data,
  output logic                  bus_rw,
  output logic                  bus_valid,
  input  logic [DATA_WIDTH-1:0] bus_resp_data,
  input  logic                  bus_resp_rw,
  input  logic                  bus_resp_valid
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  // Timer starts at 0 on the first WAIT cycle, so the expiry test looks for
  // TIMEOUT-1: the error strobe then lands TIMEOUT+1 cycles after bus_valid.
  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] timer;
  logic        last_grant;
  logic        grant_id;
  logic        pick;
  logic        accept;
  logic        resp_done;
  logic        timeout_done;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state, round-robin pick and the combinational ready handshake
  always_comb begin
    state_nxt    = state;
    accept       = 1'b0;
    resp_done    = 1'b0;
    timeout_done = 1'b0;
    pick         = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    case (state)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          accept    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (bus_resp_valid) begin
          resp_done = 1'b1;
          state_nxt = IDLE;
        end else if (timer == TIMER_LAST) begin
          timeout_done = 1'b1;
          state_nxt    = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    req0_ready = accept & ~pick;
    req1_ready = accept & pick;
  end

  // Request latch, bus strobe, response timer and response routing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant  <= 1'b1;
      grant_id    <= 1'b0;
      timer       <= '0;
      bus_addr    <= '0;
      bus_data    <= '0;
      bus_rw      <= 1'b0;
      bus_valid   <= 1'b0;
      resp0_data  <= '0;
      resp0_rw    <= 1'b0;
      resp0_err   <= 1'b0;
      resp0_valid <= 1'b0;
      resp1_data  <= '0;
      resp1_rw    <= 1'b0;
      resp1_err   <= 1'b0;
      resp1_valid <= 1'b0;
    end else begin
      bus_valid   <= accept;
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
      if (accept) begin
        last_grant <= pick;
        grant_id   <= pick;
        bus_addr   <= pick ? req1_addr : req0_addr;
        bus_data   <= pick ? req1_data : req0_data;
        bus_rw     <= pick ? req1_rw   : req0_rw;
      end
      if (state == ISSUE)     timer <= '0;
      else if (state == WAIT) timer <= timer + 16'd1;
      if (resp_done || timeout_done) begin
        if (grant_id) begin
          resp1_valid <= 1'b1;
          resp1_data  <= resp_done ? bus_resp_data : '0;
          resp1_rw    <= resp_done ? bus_resp_rw : bus_rw;
          resp1_err   <= timeout_done;
        end else begin
          resp0_valid <= 1'b1;
          resp0_data  <= resp_done ? bus_resp_data : '0;
          resp0_rw    <= resp_done ? bus_resp_rw : bus_rw;
          resp0_err   <= timeout_done;
        end
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: randomized scoreboard bench for bus_arbiter with a
// transaction-level reference model (pending queues, round-robin pointer,
// scheduled response/timeout times).
module tb_bus_arbiter;

  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int TMO = 8;

  typedef struct {logic [AW-1:0] addr; logic [DW-1:0] data; logic rw;} txn_t;
  typedef struct {int lat; logic [DW-1:0] data; logic rw;} lat_t;
  typedef struct {int cyc; logic [AW-1:0] addr; logic [DW-1:0] data; logic rw;} bus_exp_t;
  typedef struct {int cyc; int id; logic [DW-1:0] data; logic rw; logic err;} rsp_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [AW-1:0] req0_addr, req1_addr, bus_addr;
  logic [DW-1:0] req0_data, req1_data, resp0_data, resp1_data, bus_data, bus_resp_data;
  logic req0_rw, req0_valid, req0_ready, resp0_rw, resp0_err, resp0_valid;
  logic req1_rw, req1_valid, req1_ready, resp1_rw, resp1_err, resp1_valid;
  logic bus_rw, bus_valid, bus_resp_rw, bus_resp_valid;

  bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req0_addr(req0_addr), .req0_data(req0_data), .req0_rw(req0_rw),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .resp0_data(resp0_data), .resp0_rw(resp0_rw), .resp0_err(resp0_err), .resp0_valid(resp0_valid),
    .req1_addr(req1_addr), .req1_data(req1_data), .req1_rw(req1_rw),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .resp1_data(resp1_data), .resp1_rw(resp1_rw), .resp1_err(resp1_err), .resp1_valid(resp1_valid),
    .bus_addr(bus_addr), .bus_data(bus_data), .bus_rw(bus_rw), .bus_valid(bus_valid),
    .bus_resp_data(bus_resp_data), .bus_resp_rw(bus_resp_rw), .bus_resp_valid(bus_resp_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  // Reference model state
  txn_t     req_q0[$], req_q1[$];
  lat_t     lat_q[$];
  bus_exp_t bus_q[$];
  rsp_exp_t rsp_q[$];
  int       dut_grants[$];
  bit       m_free = 1'b1;
  bit       m_last = 1'b1;
  int       m_free_at = -1;
  int       issue_at = -1;
  int       resp_at = -1;
  logic [DW-1:0] resp_d;
  logic     resp_r;
  int       req_pct = 0;
  int       stale_pct = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void note_fail(input string nm, input int act, input int exp);
    total++;
    bad++;
    $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    t.addr = AW'($urandom);
    t.data = DW'($urandom);
    t.rw   = 1'($urandom);
    return t;
  endfunction

  function automatic txn_t mk_txn(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic rw);
    txn_t t;
    t.addr = a; t.data = d; t.rw = rw;
    return t;
  endfunction

  function automatic lat_t mk_lat(input int lat, input logic [DW-1:0] d, input logic rw);
    lat_t l;
    l.lat = lat; l.data = d; l.rw = rw;
    return l;
  endfunction

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_bus_valid"}, bus_valid, 0);
    chk({tag, "_bus_addr"}, bus_addr, 0);
    chk({tag, "_bus_data"}, bus_data, 0);
    chk({tag, "_bus_rw"}, bus_rw, 0);
    chk({tag, "_resp0_valid"}, resp0_valid, 0);
    chk({tag, "_resp0_data"}, resp0_data, 0);
    chk({tag, "_resp0_rw"}, resp0_rw, 0);
    chk({tag, "_resp0_err"}, resp0_err, 0);
    chk({tag, "_resp1_valid"}, resp1_valid, 0);
    chk({tag, "_resp1_data"}, resp1_data, 0);
    chk({tag, "_resp1_rw"}, resp1_rw, 0);
    chk({tag, "_resp1_err"}, resp1_err, 0);
    chk({tag, "_ready0"}, req0_ready, 0);
    chk({tag, "_ready1"}, req1_ready, 0);
  endtask

  // One clock of stimulus plus the model's acceptance decision
  task automatic step();
    txn_t t;
    lat_t l;
    bus_exp_t be;
    rsp_exp_t re;
    int g;
    @(negedge clk); #1;
    if (!m_free && cyc == m_free_at) m_free = 1'b1;
    if (req_pct > 0) begin
      if (req_q0.size() == 0 && $urandom_range(0, 99) < req_pct) req_q0.push_back(rand_txn());
      if (req_q1.size() == 0 && $urandom_range(0, 99) < req_pct) req_q1.push_back(rand_txn());
    end
    bus_resp_valid = 1'b0;
    bus_resp_data  = DW'($urandom);
    bus_resp_rw    = 1'($urandom);
    if (cyc == resp_at) begin
      bus_resp_valid = 1'b1;
      bus_resp_data  = resp_d;
      bus_resp_rw    = resp_r;
      resp_at        = -1;
    end else if ((m_free || cyc == issue_at) && $urandom_range(0, 99) < stale_pct) begin
      bus_resp_valid = 1'b1;
    end
    if (req_q0.size() > 0) begin
      req0_valid = 1'b1; req0_addr = req_q0[0].addr; req0_data = req_q0[0].data; req0_rw = req_q0[0].rw;
    end else begin
      req0_valid = 1'b0; req0_addr = AW'($urandom); req0_data = DW'($urandom); req0_rw = 1'($urandom);
    end
    if (req_q1.size() > 0) begin
      req1_valid = 1'b1; req1_addr = req_q1[0].addr; req1_data = req_q1[0].data; req1_rw = req_q1[0].rw;
    end else begin
      req1_valid = 1'b0; req1_addr = AW'($urandom); req1_data = DW'($urandom); req1_rw = 1'($urandom);
    end
    #1;
    g = -1;
    if (m_free && (req_q0.size() > 0 || req_q1.size() > 0)) begin
      if (req_q0.size() > 0 && req_q1.size() > 0) g = m_last ? 0 : 1;
      else g = (req_q0.size() > 0) ? 0 : 1;
    end
    chk("req0_ready", req0_ready, g == 0);
    chk("req1_ready", req1_ready, g == 1);
    if (req0_ready) dut_grants.push_back(0);
    if (req1_ready) dut_grants.push_back(1);
    if (g >= 0) begin
      if (g == 0) t = req_q0.pop_front();
      else        t = req_q1.pop_front();
      m_last   = (g == 1);
      m_free   = 1'b0;
      issue_at = cyc + 1;
      be.cyc = cyc + 1; be.addr = t.addr; be.data = t.data; be.rw = t.rw;
      bus_q.push_back(be);
      if (lat_q.size() > 0) l = lat_q.pop_front();
      else begin
        l.lat  = ($urandom_range(0, 99) < 15) ? 0 : int'($urandom_range(1, TMO));
        l.data = DW'($urandom);
        l.rw   = t.rw ^ ($urandom_range(0, 3) == 0);
      end
      re.id = g;
      if (l.lat > 0) begin
        resp_at   = cyc + 1 + l.lat;
        resp_d    = l.data;
        resp_r    = l.rw;
        m_free_at = resp_at + 1;
        re.cyc = m_free_at; re.data = l.data; re.rw = l.rw; re.err = 1'b0;
      end else begin
        resp_at   = -1;
        m_free_at = cyc + TMO + 2;
        re.cyc = m_free_at; re.data = '0; re.rw = t.rw; re.err = 1'b1;
      end
      rsp_q.push_back(re);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; bus_resp_valid = 1'b0;
    m_free = 1'b1; m_last = 1'b1; m_free_at = -1; issue_at = -1;
    bus_q.delete(); rsp_q.delete();
    @(negedge clk); #1;
    check_idle_outputs("rst");
    rst = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((req_q0.size() > 0 || req_q1.size() > 0 || !m_free || rsp_q.size() > 0) && n < 600) begin
      step();
      n++;
    end
    if (n >= 600) note_fail("drain_timeout", n, 600);
  endtask

  // Monitor: pops expectations whenever the DUT strobes, checks holds otherwise
  initial begin
    bus_exp_t e;
    rsp_exp_t r;
    logic [AW-1:0] h_addr;
    logic [DW-1:0] h_data, h0_d, h1_d;
    logic h_rw, h0_rw, h0_err, h1_rw, h1_err;
    int id;
    forever begin
      @(negedge clk);
      if (rst) begin
        h_addr = '0; h_data = '0; h_rw = 1'b0;
        h0_d = '0; h0_rw = 1'b0; h0_err = 1'b0;
        h1_d = '0; h1_rw = 1'b0; h1_err = 1'b0;
      end else begin
        if (bus_valid) begin
          if (bus_q.size() == 0) note_fail("bus_unexpected", 1, 0);
          else begin
            e = bus_q.pop_front();
            chk("bus_cycle", cyc, e.cyc);
            chk("bus_addr", bus_addr, e.addr);
            chk("bus_data", bus_data, e.data);
            chk("bus_rw", bus_rw, e.rw);
            h_addr = e.addr; h_data = e.data; h_rw = e.rw;
          end
        end else begin
          chk("bus_hold_addr", bus_addr, h_addr);
          chk("bus_hold_data", bus_data, h_data);
          chk("bus_hold_rw", bus_rw, h_rw);
        end
        if (resp0_valid && resp1_valid) note_fail("resp_both", 2, 1);
        else if (resp0_valid || resp1_valid) begin
          id = resp1_valid ? 1 : 0;
          if (rsp_q.size() == 0) note_fail("resp_unexpected", id, -1);
          else begin
            r = rsp_q.pop_front();
            chk("resp_id", id, r.id);
            chk("resp_cycle", cyc, r.cyc);
            if (id == 0) begin
              chk("resp0_data", resp0_data, r.data);
              chk("resp0_rw", resp0_rw, r.rw);
              chk("resp0_err", resp0_err, r.err);
            end else begin
              chk("resp1_data", resp1_data, r.data);
              chk("resp1_rw", resp1_rw, r.rw);
              chk("resp1_err", resp1_err, r.err);
            end
            if (r.id == 0) begin h0_d = r.data; h0_rw = r.rw; h0_err = r.err; end
            else           begin h1_d = r.data; h1_rw = r.rw; h1_err = r.err; end
          end
        end
        if (!resp0_valid) begin
          chk("resp0_hold_data", resp0_data, h0_d);
          chk("resp0_hold_rw", resp0_rw, h0_rw);
          chk("resp0_hold_err", resp0_err, h0_err);
        end
        if (!resp1_valid) begin
          chk("resp1_hold_data", resp1_data, h1_d);
          chk("resp1_hold_rw", resp1_rw, h1_rw);
          chk("resp1_hold_err", resp1_err, h1_err);
        end
      end
    end
  end

  // Stimulus sequence
  initial begin
    int exp_order[4];
    exp_order = '{0, 1, 0, 1};
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0; req0_rw = 1'b0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0; req1_rw = 1'b0;
    bus_resp_valid = 1'b0; bus_resp_data = '0; bus_resp_rw = 1'b0;
    do_reset();

    // single read returning 0xBEEF five cycles after the bus strobe
    req_q0.push_back(mk_txn(16'h0003, 16'h0000, 1'b0));
    lat_q.push_back(mk_lat(5, 16'hBEEF, 1'b0));
    drain();

    // simultaneous requests from reset: grant order 0,1,0,1
    do_reset();
    dut_grants.delete();
    req_q0.push_back(mk_txn(16'h0100, 16'h1000, 1'b1));
    req_q0.push_back(mk_txn(16'h0101, 16'h1001, 1'b0));
    req_q1.push_back(mk_txn(16'h0200, 16'h2000, 1'b0));
    req_q1.push_back(mk_txn(16'h0201, 16'h2001, 1'b1));
    for (int i = 0; i < 4; i++) lat_q.push_back(mk_lat(2 + i, DW'(16'hC000 + i), 1'(i)));
    drain();
    chk("grant_count", dut_grants.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < dut_grants.size()) chk("grant_order", dut_grants[i], exp_order[i]);

    // write pass-through on requester 1
    req_q1.push_back(mk_txn(16'h0010, 16'h1234, 1'b1));
    lat_q.push_back(mk_lat(3, 16'h5A5A, 1'b1));
    drain();

    // timeout, next request accepted in the error-strobe cycle
    req_q0.push_back(mk_txn(16'h0030, 16'h0000, 1'b0));
    req_q0.push_back(mk_txn(16'h0031, 16'h0000, 1'b0));
    lat_q.push_back(mk_lat(0, 16'h0000, 1'b0));
    lat_q.push_back(mk_lat(2, 16'h1111, 1'b0));
    drain();

    // stale responses while idle
    stale_pct = 100;
    repeat (6) step();
    stale_pct = 0;

    // response on the timeout cycle wins
    req_q0.push_back(mk_txn(16'h0020, 16'h0000, 1'b0));
    lat_q.push_back(mk_lat(TMO, 16'hA5A5, 1'b0));
    drain();

    // reset mid-WAIT, response arrives after release and is dropped
    req_q0.push_back(mk_txn(16'h0040, 16'h0000, 1'b0));
    lat_q.push_back(mk_lat(6, 16'h7777, 1'b0));
    step();
    repeat (3) step();
    do_reset();
    repeat (3) step();
    check_idle_outputs("post_rst");
    req_q0.push_back(mk_txn(16'h0041, 16'h0000, 1'b1));
    lat_q.push_back(mk_lat(2, 16'h2222, 1'b1));
    drain();

    // randomized traffic with stale pulses
    req_pct = 40;
    stale_pct = 25;
    repeat (500) step();
    req_pct = 0;
    stale_pct = 0;
    drain();

    chk("bus_q_empty", bus_q.size(), 0);
    chk("rsp_q_empty", rsp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
